// File: rtl/dac_spi_tx.sv
// dac_spi_tx: serialises 10-bit offset-binary samples into MCP4911 SPI frames, each followed by an LDAC pulse
//   sysclk, reset : system clock, asynchronous active-high reset
//   data_in, load : sample word and its one-cycle valid strobe
//   dac_cs_n, dac_sck, dac_sdi, dac_ld_n : SPI DAC interface (all registered)
//   busy, done, overrun : frame in progress, frame-complete pulse, held-word-overwritten pulse
module dac_spi_tx #(
    parameter int         HALF_SCK = 4,
    parameter logic [3:0] CMD_BITS = 4'b0011
) (
    input  logic       sysclk,
    input  logic       reset,
    input  logic [9:0] data_in,
    input  logic       load,
    output logic       dac_cs_n,
    output logic       dac_sck,
    output logic       dac_sdi,
    output logic       dac_ld_n,
    output logic       busy,
    output logic       done,
    output logic       overrun
);
    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP, LDAC} state_t;
    state_t      r_state, w_state;
    logic [7:0]  r_div, w_div;
    logic [5:0]  r_phase, w_phase;
    logic [15:0] r_sh, w_sh;
    logic [9:0]  r_hold, w_hold;
    logic        r_full, w_full, r_cs_n, w_cs_n, r_sck, w_sck, r_sdi, w_sdi;
    logic        r_ld_n, w_ld_n, r_busy, w_busy, r_done, w_done, r_ovr, w_ovr;
    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_div   <= '0;
            r_phase <= '0;
            r_sh    <= '0;
            r_hold  <= '0;
            r_full  <= 1'b0;
            r_cs_n  <= 1'b1;
            r_sck   <= 1'b0;
            r_sdi   <= 1'b0;
            r_ld_n  <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_ovr   <= 1'b0;
        end else begin
            r_state <= w_state;
            r_div   <= w_div;
            r_phase <= w_phase;
            r_sh    <= w_sh;
            r_hold  <= w_hold;
            r_full  <= w_full;
            r_cs_n  <= w_cs_n;
            r_sck   <= w_sck;
            r_sdi   <= w_sdi;
            r_ld_n  <= w_ld_n;
            r_busy  <= w_busy;
            r_done  <= w_done;
            r_ovr   <= w_ovr;
        end
    end
    always_comb begin
        w_state = r_state;
        w_div   = r_div;
        w_phase = r_phase;
        w_sh    = r_sh;
        w_hold  = r_hold;
        w_full  = r_full;
        w_cs_n  = r_cs_n;
        w_sck   = r_sck;
        w_sdi   = r_sdi;
        w_ld_n  = r_ld_n;
        w_busy  = r_busy;
        w_done  = 1'b0;
        w_ovr   = 1'b0;
        if (r_state == IDLE) begin
            if (load || r_full) begin
                // a held word has priority; a load arriving alongside it becomes the next held word
                w_sh    = {CMD_BITS, r_full ? r_hold : data_in, 2'b00};
                w_state = SETUP;
                w_div   = '0;
                w_phase = '0;
                w_cs_n  = 1'b0;
                w_sck   = 1'b0;
                w_sdi   = w_sh[15];
                w_busy  = 1'b1;
                w_full  = r_full && load;
                w_hold  = (r_full && load) ? data_in : r_hold;
            end
        end else begin
            if (load) begin
                w_hold = data_in;
                w_full = 1'b1;
                w_ovr  = r_full;
            end
            if (r_div != 8'(HALF_SCK - 1)) begin
                w_div = r_div + 8'd1;
            end else begin
                w_div   = '0;
                w_phase = r_phase + 6'd1;
                if (r_state == LDAC) begin
                    w_state = IDLE;
                    w_phase = '0;
                    w_ld_n  = 1'b1;
                    w_busy  = 1'b0;
                    w_done  = 1'b1;
                end else if (w_phase <= 6'd31) begin
                    // odd phases drive SCK high; data advances at the start of each even (low) phase
                    w_state = SHIFT;
                    w_sck   = w_phase[0];
                    if (!w_phase[0]) begin
                        w_sh  = r_sh << 1;
                        w_sdi = r_sh[14];
                    end
                end else if (w_phase == 6'd32) begin
                    w_state = HOLD;
                    w_sck   = 1'b0;
                end else if (w_phase == 6'd33) begin
                    w_state = GAP;
                    w_cs_n  = 1'b1;
                    w_sdi   = 1'b0;
                end else begin
                    w_state = LDAC;
                    w_ld_n  = 1'b0;
                end
            end
        end
    end
    assign dac_cs_n = r_cs_n;
    assign dac_sck  = r_sck;
    assign dac_sdi  = r_sdi;
    assign dac_ld_n = r_ld_n;
    assign busy     = r_busy;
    assign done     = r_done;
    assign overrun  = r_ovr;
endmodule

// File: tb/tb_dac_spi_tx.sv
// tb_dac_spi_tx: random and directed stimulus on two instances (HALF_SCK 2 and 1) against a timeline reference model
module tb_dac_spi_tx;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       load = 1'b0;
    logic [9:0] data_in = '0;
    int         n_vec = 0;
    int         n_err = 0;
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic got, input logic exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            if (n_err <= 20) $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask
    for (genvar g = 0; g < 2; g++) begin : u
        localparam int H = g ? 1 : 2;
        logic        cs_n, sck, sdi, ld_n, busy, done, ovr;
        logic        act, full, e_done, e_ovr;
        logic [9:0]  hold;
        logic [15:0] word;
        int          el, p;
        dac_spi_tx #(.HALF_SCK(H)) dut (
            .sysclk(clk), .reset(reset), .data_in(data_in), .load(load),
            .dac_cs_n(cs_n), .dac_sck(sck), .dac_sdi(sdi), .dac_ld_n(ld_n),
            .busy(busy), .done(done), .overrun(ovr)
        );
        // el counts edges since the frame-start edge; the frame occupies 35 phases of H cycles
        initial begin
            act = 1'b0;
            full = 1'b0;
            hold = '0;
            word = '0;
            el = 0;
            forever begin
                @(posedge clk);
                e_done = 1'b0;
                e_ovr = 1'b0;
                if (reset) begin
                    act = 1'b0;
                    full = 1'b0;
                end else if (act) begin
                    el++;
                    if (load) begin
                        e_ovr = full;
                        hold = data_in;
                        full = 1'b1;
                    end
                    if (el == 35 * H) begin
                        act = 1'b0;
                        e_done = 1'b1;
                    end
                end else if (load || full) begin
                    word = {4'b0011, full ? hold : data_in, 2'b00};
                    if (full && load) hold = data_in;
                    else full = 1'b0;
                    act = 1'b1;
                    el = 0;
                end
                p = el / H;
                #1;
                chk($sformatf("H%0d busy", H), busy, act);
                chk($sformatf("H%0d cs_n", H), cs_n, !(act && p < 33));
                chk($sformatf("H%0d sck", H), sck, act && p < 32 && p % 2 == 1);
                chk($sformatf("H%0d sdi", H), sdi, act && (p <= 31 ? word[15 - p / 2] : (p == 32 ? word[0] : 1'b0)));
                chk($sformatf("H%0d ld_n", H), ld_n, !(act && p == 34));
                chk($sformatf("H%0d done", H), done, e_done);
                chk($sformatf("H%0d overrun", H), ovr, e_ovr);
            end
        end
    end
    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask
    task automatic send(input logic [9:0] d);
        @(negedge clk);
        load = 1'b1;
        data_in = d;
        @(negedge clk);
        load = 1'b0;
        data_in = 10'($urandom);
    endtask
    // asynchronous reset between edges: outputs must drop to reset values before any clock edge
    task automatic rst_pulse();
        @(negedge clk);
        #2 reset = 1'b1;
        load = 1'b0;
        #1;
        chk("async rst H2", u[0].cs_n & !u[0].sck & !u[0].sdi & u[0].ld_n & !u[0].busy & !u[0].done & !u[0].ovr, 1'b1);
        chk("async rst H1", u[1].cs_n & !u[1].sck & !u[1].sdi & u[1].ld_n & !u[1].busy & !u[1].done & !u[1].ovr, 1'b1);
        @(negedge clk);
        reset = 1'b0;
    endtask
    initial begin
        int rate;
        idle(3);
        reset = 1'b0;
        send(10'h2AB);
        idle(80);
        send(10'h000);
        idle(9);
        send(10'h3FF);
        idle(150);
        send(10'h155);
        idle(9);
        send(10'h0AA);
        idle(150);
        send(10'h001);
        idle(9);
        send(10'h002);
        idle(9);
        send(10'h003);
        idle(150);
        send(10'h2AB);
        idle(29);
        rst_pulse();
        idle(80);
        rate = 20;
        for (int i = 0; i < 4000; i++) begin
            if (i % 200 == 0) rate = $urandom_range(80, 3);
            if ($urandom_range(400) == 0) begin
                rst_pulse();
            end else begin
                @(negedge clk);
                load = ($urandom_range(rate - 1) == 0);
                data_in = 10'($urandom);
            end
        end
        @(negedge clk);
        load = 1'b0;
        idle(80);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
